// File: rtl/ttte_ser_frame_tx.sv
// ttte_ser_frame_tx
//   Framed multi-lane serializer. Each accepted DATA_W-bit word is split into
//   LANES slices of W = DATA_W/LANES bits. Every lane sends one frame built from
//   a start bit (0), W data bits, an optional even-parity bit and a stop bit (1).
//   Each serial bit lasts BIT_CYC clocks. One bit timer is shared by all lanes,
//   so the lanes stay bit-aligned. A one-word holding register lets the next
//   frame start in the cycle right after the previous stop bit.
//
// Ports
//   t_clk      in   clock, rising edge
//   rst        in   synchronous active-high reset
//   tx_valid   in   data_in holds a word to send
//   data_in    in   [DATA_W-1:0] word, sampled only on accept
//   tx_ready   out  a word can be accepted this cycle
//   data_out   out  [LANES-1:0] serial lines, idle high, registered
//   busy       out  a frame is on the lines (START..STOP)
//   frame_done out  one-cycle pulse in the last cycle of every stop bit
//
// Handshake: a word transfers on a rising edge where tx_valid && tx_ready.
// tx_ready does not depend on tx_valid. When tx_valid is high and tx_ready is
// low, nothing is captured and nothing is flagged. The sender may drop
// tx_valid or change data_in at any time.

module ttte_ser_frame_tx #(
  parameter int DATA_W    = 32,
  parameter int LANES     = 1,
  parameter int BIT_CYC   = 4,
  parameter int PARITY_EN = 1,
  parameter int MSB_FIRST = 0
) (
  input  logic              t_clk,
  input  logic              rst,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] data_in,
  output logic              tx_ready,
  output logic [LANES-1:0]  data_out,
  output logic              busy,
  output logic              frame_done
);

  localparam int W     = DATA_W / LANES;
  localparam int CNT_W = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
  localparam int BIT_W = $clog2(W) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BIT_CYC - 1);
  localparam logic [BIT_W-1:0] BIT_MAX = BIT_W'(W - 1);

  generate
    if ((DATA_W % LANES) != 0 || BIT_CYC < 1) begin : g_bad_params
      $error("ttte_ser_frame_tx: DATA_W must be a multiple of LANES and BIT_CYC >= 1");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  // Even parity of every lane slice of a word.
  function automatic logic [LANES-1:0] lane_parity(input logic [DATA_W-1:0] w);
    logic [LANES-1:0] p;
    for (int i = 0; i < LANES; i++) p[i] = ^w[i*W +: W];
    return p;
  endfunction

  // Move every lane by one position so the next bit reaches the head.
  function automatic logic [DATA_W-1:0] lane_shift(input logic [DATA_W-1:0] w);
    logic [DATA_W-1:0] r;
    for (int i = 0; i < LANES; i++) begin
      if (MSB_FIRST != 0) r[i*W +: W] = w[i*W +: W] << 1;
      else                r[i*W +: W] = w[i*W +: W] >> 1;
    end
    return r;
  endfunction

  // Bit now being sent on each lane: MSB of the slice, or LSB.
  function automatic logic [LANES-1:0] lane_head(input logic [DATA_W-1:0] w);
    logic [LANES-1:0] h;
    for (int i = 0; i < LANES; i++) begin
      if (MSB_FIRST != 0) h[i] = w[i*W + W - 1];
      else                h[i] = w[i*W];
    end
    return h;
  endfunction

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [LANES-1:0]  par_q, par_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              hold_full_q, hold_full_d;
  logic [LANES-1:0]  data_out_q, data_out_d;
  logic              busy_q, busy_d;
  logic              frame_done_q, frame_done_d;

  logic accept;
  logic last_cyc;
  logic load_direct;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_d        = bit_q;
    shreg_d      = shreg_q;
    par_d        = par_q;
    hold_d       = hold_q;
    hold_full_d  = hold_full_q;
    load_direct  = 1'b0;

    tx_ready = (state_q == S_IDLE) | ~hold_full_q;
    accept   = tx_valid & tx_ready;
    last_cyc = (cnt_q == CNT_MAX);

    // The bit timer runs only while a frame is on the lines.
    if (state_q != S_IDLE) cnt_d = last_cyc ? '0 : cnt_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          load_direct = 1'b1;
          shreg_d     = data_in;
          par_d       = lane_parity(data_in);
          cnt_d       = '0;
          state_d     = S_START;
        end
      end
      S_START: begin
        if (last_cyc) begin
          bit_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (last_cyc) begin
          if (bit_q == BIT_MAX) begin
            state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_d   = bit_q + 1'b1;
            shreg_d = lane_shift(shreg_q);
          end
        end
      end
      S_PARITY: begin
        if (last_cyc) state_d = S_STOP;
      end
      S_STOP: begin
        if (last_cyc) begin
          if (hold_full_q) begin
            // tx_ready is low here, so no accept can land on this edge.
            shreg_d     = hold_q;
            par_d       = lane_parity(hold_q);
            hold_full_d = 1'b0;
            state_d     = S_START;
          end else if (accept) begin
            // The holding register is empty and this is the frame's last edge.
            // Load the word straight in so it is not left stranded in the
            // holding register while the FSM is idle.
            load_direct = 1'b1;
            shreg_d     = data_in;
            par_d       = lane_parity(data_in);
            state_d     = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    if (accept && !load_direct) begin
      hold_d      = data_in;
      hold_full_d = 1'b1;
    end

    // The outputs come from the next state, so the registers match it.
    busy_d       = (state_d != S_IDLE);
    frame_done_d = (state_d == S_STOP) && (cnt_d == CNT_MAX);
    case (state_d)
      S_START:  data_out_d = '0;
      S_DATA:   data_out_d = lane_head(shreg_d);
      S_PARITY: data_out_d = par_d;
      default:  data_out_d = '1;
    endcase
  end

  always_ff @(posedge t_clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      shreg_q      <= '0;
      par_q        <= '0;
      hold_q       <= '0;
      hold_full_q  <= 1'b0;
      data_out_q   <= '1;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      shreg_q      <= shreg_d;
      par_q        <= par_d;
      hold_q       <= hold_d;
      hold_full_q  <= hold_full_d;
      data_out_q   <= data_out_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign data_out   = data_out_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_ttte_ser_frame_tx.sv
// Testbench for ttte_ser_frame_tx. Three instances are built:
//   dut    : default configuration, checked cycle by cycle against a queue of
//            expected {busy, frame_done, data_out} values
//   dut_l4 : LANES=4, BIT_CYC=1, PARITY_EN=0
//   dut_msb: MSB_FIRST=1
module tb_ttte_ser_frame_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        tx_valid;
  logic [31:0] data_in;
  logic        tx_ready;
  logic [0:0]  data_out;
  logic        busy, frame_done;

  logic        l4_valid;
  logic [31:0] l4_data;
  logic        l4_ready;
  logic [3:0]  l4_out;
  logic        l4_busy, l4_fd;

  logic        m_valid;
  logic [31:0] m_data;
  logic        m_ready;
  logic [0:0]  m_out;
  logic        m_busy, m_fd;

  ttte_ser_frame_tx dut (
    .t_clk(clk), .rst(rst), .tx_valid(tx_valid), .data_in(data_in),
    .tx_ready(tx_ready), .data_out(data_out), .busy(busy), .frame_done(frame_done)
  );

  ttte_ser_frame_tx #(.DATA_W(32), .LANES(4), .BIT_CYC(1), .PARITY_EN(0), .MSB_FIRST(0)) dut_l4 (
    .t_clk(clk), .rst(rst), .tx_valid(l4_valid), .data_in(l4_data),
    .tx_ready(l4_ready), .data_out(l4_out), .busy(l4_busy), .frame_done(l4_fd)
  );

  ttte_ser_frame_tx #(.DATA_W(32), .LANES(1), .BIT_CYC(4), .PARITY_EN(1), .MSB_FIRST(1)) dut_msb (
    .t_clk(clk), .rst(rst), .tx_valid(m_valid), .data_in(m_data),
    .tx_ready(m_ready), .data_out(m_out), .busy(m_busy), .frame_done(m_fd)
  );

  int errors = 0;
  int checks = 0;

  // Expected {busy, frame_done, data_out} of dut, one entry per clock cycle.
  logic [2:0] exp_q[$];
  logic       mon_en = 1'b0;
  int         fd_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: pop one expectation per cycle; an empty queue means idle.
  always @(negedge clk) begin
    logic [2:0] e;
    if (mon_en) begin
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else                  e = 3'b001;
      check("dut_cycle", {busy, frame_done, data_out}, e);
      if (frame_done) fd_cnt++;
    end
  end

  // Default configuration: 4 cycles per bit, LSB first, even parity.
  task automatic push_frame(input logic [31:0] w, input logic par);
    for (int c = 0; c < 4; c++) exp_q.push_back(3'b100);
    for (int b = 0; b < 32; b++)
      for (int c = 0; c < 4; c++) exp_q.push_back({2'b10, w[b]});
    for (int c = 0; c < 4; c++) exp_q.push_back({2'b10, par});
    for (int c = 0; c < 3; c++) exp_q.push_back(3'b101);
    exp_q.push_back(3'b111);
  endtask

  // Starts and ends at a negedge. tx_valid stays high until the word is accepted.
  task automatic send(input logic [31:0] w, input logic par);
    logic acc;
    int   waited;
    int   qs;
    acc = 1'b0; waited = 0; qs = 0;
    tx_valid = 1'b1;
    data_in  = w;
    while (!acc && waited < 400) begin
      acc = tx_ready;
      @(posedge clk);
      if (acc) begin
        qs = exp_q.size();
        push_frame(w, par);
      end else begin
        waited++;
      end
      @(negedge clk);
    end
    tx_valid = 1'b0;
    data_in  = $urandom();
    if (!acc) begin
      checks++; errors++;
      $display("FAIL send_timeout: word %h never accepted", w);
    end else begin
      // The word is loaded directly only if no frame was still running.
      // Otherwise it waits in the holding register and tx_ready must drop.
      check("tx_ready_after_accept", {31'd0, tx_ready}, {31'd0, (qs == 0)});
    end
  endtask

  task automatic drain(input int extra);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() > 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d cycles left, required 0", exp_q.size());
    end
    repeat (extra) @(negedge clk);
  endtask

  typedef struct {
    logic [31:0] word;
    logic        par;
    logic        last;
  } vec_t;

  vec_t vec[4];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int grp_fd;
    int grp_words;
    logic [7:0]  lb0, lb1, lb2, lb3;
    logic [31:0] mw;
    logic [5:0]  e6;
    logic [2:0]  e3;
    int k;

    vec[0] = '{32'hA201BEAF, 1'b0, 1'b1};
    vec[1] = '{32'hA201BEAF, 1'b0, 1'b0};
    vec[2] = '{32'hA612BEAF, 1'b0, 1'b0};
    vec[3] = '{32'hA623BEAF, 1'b1, 1'b1};

    rst = 1'b1;
    tx_valid = 1'b0; data_in = $urandom();
    l4_valid = 1'b0; l4_data = $urandom();
    m_valid  = 1'b0; m_data  = $urandom();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    check("rst_data_out", {31'd0, data_out}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_frame_done", {31'd0, frame_done}, 32'd0);
    check("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
    check("rst_l4_out", {28'd0, l4_out}, 32'hF);
    check("rst_msb_busy", {31'd0, m_busy}, 32'd0);
    mon_en = 1'b1;

    // Single frame, then three contiguous frames with tx_valid held high.
    grp_fd = fd_cnt; grp_words = 0;
    for (int i = 0; i < 4; i++) begin
      if (grp_words == 0) grp_fd = fd_cnt;
      send(vec[i].word, vec[i].par);
      grp_words++;
      if (vec[i].last) begin
        drain(4);
        check("frame_done_count", fd_cnt - grp_fd, grp_words);
        grp_words = 0;
        repeat ($urandom_range(1, 5)) @(negedge clk);
      end
    end

    // tx_valid with all-ones data while the holding register is full is ignored.
    grp_fd = fd_cnt;
    send(32'hA201BEAF, 1'b0);
    send(32'hA612BEAF, 1'b0);
    tx_valid = 1'b1;
    data_in  = 32'hFFFFFFFF;
    check("ready_low_hold_full", {31'd0, tx_ready}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    tx_valid = 1'b0;
    send(32'hA623BEAF, 1'b1);
    drain(4);
    check("ignored_word_frames", fd_cnt - grp_fd, 3);

    // Reset for two cycles in the middle of a frame, with the holding register full.
    send(32'hA201BEAF, 1'b0);
    send(32'hA612BEAF, 1'b0);
    repeat (30) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    exp_q.delete();
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("midrst_data_out", {31'd0, data_out}, 32'd1);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_tx_ready", {31'd0, tx_ready}, 32'd1);
    check("midrst_frame_done", {31'd0, frame_done}, 32'd0);
    repeat (20) @(negedge clk);
    send(32'hA201BEAF, 1'b0);
    drain(4);

    // Four lanes, one cycle per bit, no parity.
    lb0 = 8'h78; lb1 = 8'h56; lb2 = 8'h34; lb3 = 8'h12;
    l4_valid = 1'b1;
    l4_data  = 32'h12345678;
    check("l4_ready", {31'd0, l4_ready}, 32'd1);
    @(posedge clk);
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      if (c == 0) begin
        l4_valid = 1'b0;
        l4_data  = $urandom();
      end
      if (c == 0)      e6 = 6'b10_0000;
      else if (c <= 8) e6 = {2'b10, lb3[c-1], lb2[c-1], lb1[c-1], lb0[c-1]};
      else if (c == 9) e6 = 6'b11_1111;
      else             e6 = 6'b00_1111;
      check("l4_cycle", {26'd0, l4_busy, l4_fd, l4_out}, {26'd0, e6});
    end

    // MSB first.
    mw = 32'h80000001;
    m_valid = 1'b1;
    m_data  = mw;
    check("msb_ready", {31'd0, m_ready}, 32'd1);
    @(posedge clk);
    for (int n = 0; n < 141; n++) begin
      @(negedge clk);
      if (n == 0) begin
        m_valid = 1'b0;
        m_data  = $urandom();
      end
      k = n / 4;
      if (n == 140)     e3 = 3'b001;
      else if (k == 0)  e3 = 3'b100;
      else if (k <= 32) e3 = {2'b10, mw[32-k]};
      else if (k == 33) e3 = 3'b100;
      else              e3 = {1'b1, (n == 139), 1'b1};
      check("msb_cycle", {29'd0, m_busy, m_fd, m_out}, {29'd0, e3});
    end

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
